// File: rtl/sms_oc_bus_arbiter.sv
// Round-robin arbiter for a shared open-collector (dot-OR) line: one owner at a time,
// bounded hold, a driver-free turnaround gap between owners, and stray-driver detection.
module sms_oc_bus_arbiter #(
  parameter int N        = 4,
  parameter int TURN     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  input  logic         bus_sense,
  output logic [N-1:0] grant,
  output logic [N-1:0] oc_enable,
  output logic         busy,
  output logic         timeout,
  output logic         stray_fault
);

  localparam int PW = $clog2(N);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]    state_reg;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] owner_reg;
  logic [7:0]    hold_cnt_reg;
  logic [3:0]    turn_cnt_reg;
  logic [N-1:0]  grant_reg;
  logic          timeout_reg;
  logic          stray_hit_reg;
  logic          stray_fault_reg;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          owner_done;
  logic          owner_req;
  logic          hold_limit;
  logic          grant_exit;
  logic [PW-1:0] ptr_next;
  logic          stray_check;
  logic          stray_hit;

  // First requesting index at or after ptr, wrapping; scanning downward lets the
  // smallest offset overwrite any later candidate.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign owner_done = done[owner_reg];
  assign owner_req  = req[owner_reg];
  assign hold_limit = (hold_cnt_reg == 8'(MAX_HOLD - 1));
  assign grant_exit = owner_done || !owner_req || hold_limit;
  assign ptr_next   = (owner_reg == PW'(N - 1)) ? '0 : PW'(owner_reg + 1'b1);

  // The first RELEASE cycle is exempt so the previous owner's stage can let the line float.
  assign stray_check = (state_reg == S_IDLE) ||
                       ((state_reg == S_RELEASE) && (turn_cnt_reg != 4'd0));
  assign stray_hit   = stray_check && bus_sense;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      hold_cnt_reg    <= '0;
      turn_cnt_reg    <= '0;
      grant_reg       <= '0;
      timeout_reg     <= 1'b0;
      stray_hit_reg   <= 1'b0;
      stray_fault_reg <= 1'b0;
    end else begin
      timeout_reg   <= 1'b0;
      stray_hit_reg <= stray_hit;
      if (stray_hit && stray_hit_reg) stray_fault_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            grant_reg    <= N'(1) << pick_idx;
            owner_reg    <= pick_idx;
            hold_cnt_reg <= '0;
            state_reg    <= S_GRANT;
          end
        end
        S_GRANT: begin
          hold_cnt_reg <= hold_cnt_reg + 8'd1;
          if (grant_exit) begin
            grant_reg    <= '0;
            ptr_reg      <= ptr_next;
            turn_cnt_reg <= '0;
            state_reg    <= S_RELEASE;
            // Revocation by the hold limit alone; a release or dropped request wins a tie.
            timeout_reg  <= owner_req && !owner_done;
          end
        end
        S_RELEASE: begin
          turn_cnt_reg <= turn_cnt_reg + 4'd1;
          if (turn_cnt_reg == 4'(TURN - 1)) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign oc_enable   = grant_reg;
  assign busy        = (state_reg != S_IDLE);
  assign timeout     = timeout_reg;
  assign stray_fault = stray_fault_reg;

endmodule
